multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle MIPS control FSM. Sequences a shared-ALU, single-memory datapath (PC, IR, MDR, A/B, ALUOut registers) over 3–5 cycles per instruction.
- Takes the 6-bit opcode from the IR plus a memory-ready handshake. Emits per-state datapath enables and mux selects.
- Sits beside the single-cycle decoder in the processor top and replaces it in the multi-cycle build.

Parameters:
- STATE_W, 4, width of state register and of the debug state output.
- CNT_W, 32, width of the performance counters (used only when the optional feature is enabled).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  IR[31:26], valid from DECODE onward
- memReady  input  1  memory completes the current read/write this cycle
- pcWrite  output  1  unconditional PC load
- pcWriteCond  output  1  PC load if ALU zero (beq)
- iorD  output  1  memory address select: 0=PC, 1=ALUOut
- memRead  output  1  memory read request
- memWrite  output  1  memory write request
- irWrite  output  1  IR load
- memToReg  output  1  register write data select: 0=ALUOut, 1=MDR
- regDst  output  1  destination register select: 0=rt, 1=rd
- regWrite  output  1  register file write
- aluSrcA  output  1  ALU A select: 0=PC, 1=A
- aluSrcB  output  2  ALU B select: 00=B, 01=4, 10=sext imm, 11=sext imm<<2
- aluOp  output  2  00=add, 01=sub, 10=funct
- pcSource  output  2  00=ALU, 01=ALUOut, 10=jump target
- illegalOp  output  1  undefined opcode seen in DECODE
- halted  output  1  core halted
- state  output  STATE_W  current state (debug)

Behaviour:
- Reset: async on rst_n=0. State goes to IDLE and every output is 0; no outputs are z or x. Reset mid-instruction aborts with no further pc/reg/mem writes.
- IDLE: all outputs 0. Goes to FETCH on the next clock.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010, halt=111111. Everything else is illegal.
- Outputs are Moore (from state), except irWrite and pcWrite in FETCH, which are additionally ANDed with memReady.
- FETCH:
  - Outputs: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00; irWrite=pcWrite=memReady.
  - Stays in FETCH while memReady=0; goes to DECODE when memReady=1.
- DECODE:
  - Outputs: aluSrcA=0, aluSrcB=11, aluOp=00 (branch target into ALUOut).
  - Next state by opcode: lw/sw→MEM_ADDR, R→EXECUTE, beq→BRANCH, addi→ADDI_EX, j→JUMP, halt→HALT.
  - Illegal opcode: illegalOp=1 for this cycle, next state FETCH. The instruction is skipped; PC is already incremented.
- MEM_ADDR: aluSrcA=1, aluSrcB=10, aluOp=00. Goes to MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: memRead=1, iorD=1. Holds until memReady=1, then goes to MEM_WB.
- MEM_WB: regWrite=1, memToReg=1, regDst=0. Goes to FETCH.
- MEM_WRITE: memWrite=1, iorD=1. Holds until memReady=1, then goes to FETCH.
- EXECUTE: aluSrcA=1, aluSrcB=00, aluOp=10. Goes to R_WB.
- R_WB: regWrite=1, regDst=1, memToReg=0. Goes to FETCH.
- ADDI_EX: aluSrcA=1, aluSrcB=10, aluOp=00. Goes to ADDI_WB.
- ADDI_WB: regWrite=1, regDst=0, memToReg=0. Goes to FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01. Goes to FETCH.
- JUMP: pcWrite=1, pcSource=10. Goes to FETCH.
- HALT: halted=1, all other outputs 0. Terminal; only rst_n exits.
- Latency with memReady tied 1: R=4, lw=5, sw=4, addi=4, beq=3, j=3 cycles.
- Each memReady=0 cycle in FETCH/MEM_READ/MEM_WRITE adds one cycle and holds outputs stable.
- memRead and memWrite are never both 1. memReady outside memory states is ignored.

Optional Feature:
- Macro: MC_PERF_COUNTERS_EN.
- Enabled:
  - Adds outputs cycleCount[CNT_W] and instrCount[CNT_W], both reset to 0.
  - cycleCount increments every cycle except IDLE/HALT.
  - instrCount increments on each transition into FETCH from a non-IDLE state.
  - Both wrap modulo 2^CNT_W.
- Disabled: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package mc_ctrl_pkg holds:
  - opcode localparams;
  - state encodings (IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXECUTE=7, R_WB=8, ADDI_EX=9, ADDI_WB=10, BRANCH=11, JUMP=12, HALT=13);
  - aluOp, aluSrcB and pcSource codes.
- One sub-module, mc_ctrl_decode: a combinational state→control-word ROM. The top holds the state register, next-state logic, memReady gating and counters.

Test Plan:
- Reset with rst_n=0 mid-MEM_READ → state=0, all outputs 0 asynchronously. Release → FETCH on the 2nd edge.
- opcode=100011, memReady=1 → states 1,2,3,4,5,1. regWrite=1 and memToReg=1 only in state 5. Total 5 cycles.
- opcode=101011 with memReady low for 3 cycles in MEM_WRITE → memWrite held for 4 cycles, then FETCH. No regWrite at any point.
- opcode=000100 → BRANCH with pcWriteCond=1, aluOp=01, pcSource=01. opcode=000010 → JUMP with pcWrite=1, pcSource=10. Both take 3 cycles.
- opcode=010101 → illegalOp pulses 1 cycle in DECODE, then FETCH. opcode=111111 → halted=1 and held for 20 cycles with no write enables.
- With MC_PERF_COUNTERS_EN: run R, addi, lw (memReady=1) → instrCount=3, cycleCount=13.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: opcodes, states,
// datapath select codes and the per-state control word.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        EXECUTE   = 4'd7,
        R_WB      = 4'd8,
        ADDI_EX   = 4'd9,
        ADDI_WB   = 4'd10,
        BRANCH    = 4'd11,
        JUMP      = 4'd12,
        HALT      = 4'd13
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memToReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSource;
        logic       halted;
    } ctrlWord_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> control-word ROM. FETCH emits raw irWrite/pcWrite;
// the top gates them with memReady.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t    curState,
    output ctrlWord_t ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (curState)
            FETCH: begin
                ctrl.memRead  = 1'b1;
                ctrl.irWrite  = 1'b1;
                ctrl.pcWrite  = 1'b1;
                ctrl.aluSrcB  = SRCB_FOUR;
                ctrl.aluOp    = ALUOP_ADD;
                ctrl.pcSource = PCSRC_ALU;
            end
            DECODE: begin
                ctrl.aluSrcB = SRCB_IMMSH2;
                ctrl.aluOp   = ALUOP_ADD;
            end
            MEM_ADDR, ADDI_EX: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluOp   = ALUOP_ADD;
            end
            MEM_READ: begin
                ctrl.memRead = 1'b1;
                ctrl.iorD    = 1'b1;
            end
            MEM_WB: begin
                ctrl.regWrite = 1'b1;
                ctrl.memToReg = 1'b1;
            end
            MEM_WRITE: begin
                ctrl.memWrite = 1'b1;
                ctrl.iorD     = 1'b1;
            end
            EXECUTE: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_B;
                ctrl.aluOp   = ALUOP_FUNCT;
            end
            R_WB: begin
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = 1'b1;
            end
            ADDI_WB: ctrl.regWrite = 1'b1;
            BRANCH: begin
                ctrl.aluSrcA     = 1'b1;
                ctrl.aluSrcB     = SRCB_B;
                ctrl.aluOp       = ALUOP_SUB;
                ctrl.pcWriteCond = 1'b1;
                ctrl.pcSource    = PCSRC_ALUOUT;
            end
            JUMP: begin
                ctrl.pcWrite  = 1'b1;
                ctrl.pcSource = PCSRC_JUMP;
            end
            HALT: ctrl.halted = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: state register, next-state logic, FETCH handshake gating.
// Optional performance counters are enabled with MC_PERF_COUNTERS_EN.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int STATE_W = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               memReady,
    output logic               pcWrite,
    output logic               pcWriteCond,
    output logic               iorD,
    output logic               memRead,
    output logic               memWrite,
    output logic               irWrite,
    output logic               memToReg,
    output logic               regDst,
    output logic               regWrite,
    output logic               aluSrcA,
    output logic [1:0]         aluSrcB,
    output logic [1:0]         aluOp,
    output logic [1:0]         pcSource,
    output logic               illegalOp,
    output logic               halted,
    output logic [STATE_W-1:0] state
`ifdef MC_PERF_COUNTERS_EN
    ,
    output logic [CNT_W-1:0]   cycleCount,
    output logic [CNT_W-1:0]   instrCount
`endif
);

    state_t    curState;
    state_t    nextState;
    ctrlWord_t ctrl;
    logic      fetchGate;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) curState <= IDLE;
        else        curState <= nextState;
    end

    always_comb begin
        nextState = curState;
        illegalOp = 1'b0;
        unique case (curState)
            IDLE:     nextState = FETCH;
            FETCH:    if (memReady) nextState = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: nextState = MEM_ADDR;
                    OP_RTYPE:     nextState = EXECUTE;
                    OP_BEQ:       nextState = BRANCH;
                    OP_ADDI:      nextState = ADDI_EX;
                    OP_J:         nextState = JUMP;
                    OP_HALT:      nextState = HALT;
                    default: begin
                        nextState = FETCH;
                        illegalOp = 1'b1;
                    end
                endcase
            end
            MEM_ADDR:  nextState = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
            MEM_READ:  if (memReady) nextState = MEM_WB;
            MEM_WRITE: if (memReady) nextState = FETCH;
            EXECUTE:   nextState = R_WB;
            ADDI_EX:   nextState = ADDI_WB;
            MEM_WB, R_WB, ADDI_WB, BRANCH, JUMP: nextState = FETCH;
            HALT:      nextState = HALT;
            default:   nextState = IDLE;
        endcase
    end

    mc_ctrl_decode uDecode (
        .curState (curState),
        .ctrl     (ctrl)
    );

    // Only FETCH's IR/PC loads wait on memory; JUMP's pcWrite is unconditional.
    assign fetchGate   = (curState == FETCH) ? memReady : 1'b1;
    assign pcWrite     = ctrl.pcWrite & fetchGate;
    assign irWrite     = ctrl.irWrite & fetchGate;
    assign pcWriteCond = ctrl.pcWriteCond;
    assign iorD        = ctrl.iorD;
    assign memRead     = ctrl.memRead;
    assign memWrite    = ctrl.memWrite;
    assign memToReg    = ctrl.memToReg;
    assign regDst      = ctrl.regDst;
    assign regWrite    = ctrl.regWrite;
    assign aluSrcA     = ctrl.aluSrcA;
    assign aluSrcB     = ctrl.aluSrcB;
    assign aluOp       = ctrl.aluOp;
    assign pcSource    = ctrl.pcSource;
    assign halted      = ctrl.halted;
    assign state       = STATE_W'(curState);

`ifdef MC_PERF_COUNTERS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycleCount <= '0;
            instrCount <= '0;
        end else begin
            if (curState != IDLE && curState != HALT)
                cycleCount <= cycleCount + CNT_W'(1);
            if (nextState == FETCH && curState != FETCH && curState != IDLE)
                instrCount <= instrCount + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed scoreboard bench for multicycle_control: expected state/control words
// are queued as stimulus is driven and compared on the following falling edge.
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       memReady;
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic       memToReg, regDst, regWrite, aluSrcA, illegalOp, halted;
    logic [1:0] aluSrcB, aluOp, pcSource;
    logic [3:0] state;
`ifdef MC_PERF_COUNTERS_EN
    logic [31:0] cycleCount, instrCount;
`endif

    int errors = 0;
    int checks = 0;

    logic [21:0] expQ[$];
    string       tagQ[$];
    logic [21:0] obs;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
    localparam logic [5:0] HLT = 6'b111111, ILL = 6'b010101;

    multicycle_control #(.STATE_W(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .memReady(memReady),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
        .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
        .memToReg(memToReg), .regDst(regDst), .regWrite(regWrite),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
        .pcSource(pcSource), .illegalOp(illegalOp), .halted(halted),
        .state(state)
`ifdef MC_PERF_COUNTERS_EN
        , .cycleCount(cycleCount), .instrCount(instrCount)
`endif
    );

    assign obs = {state, pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
                  memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource,
                  illegalOp, halted};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected control outputs for a state, transcribed from the state table.
    function automatic logic [17:0] expCtl(input logic [3:0] s, input logic rdy,
                                           input logic [5:0] op);
        logic pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa, ill, hl;
        logic [1:0] sb, ao, ps;
        pw = 0; pwc = 0; iord = 0; mr = 0; mw = 0; irw = 0; m2r = 0;
        rd = 0; rw = 0; sa = 0; ill = 0; hl = 0; sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (s)
            4'd1:  begin pw = rdy; irw = rdy; mr = 1; sb = 2'b01; end
            4'd2:  begin
                sb  = 2'b11;
                ill = !(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                   6'b001000, 6'b000010, 6'b111111});
            end
            4'd3:  begin sa = 1; sb = 2'b10; end
            4'd4:  begin mr = 1; iord = 1; end
            4'd5:  begin rw = 1; m2r = 1; end
            4'd6:  begin mw = 1; iord = 1; end
            4'd7:  begin sa = 1; ao = 2'b10; end
            4'd8:  begin rw = 1; rd = 1; end
            4'd9:  begin sa = 1; sb = 2'b10; end
            4'd10: rw = 1;
            4'd11: begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
            4'd12: begin pw = 1; ps = 2'b10; end
            4'd13: hl = 1;
            default: ;
        endcase
        return {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, ao, ps, ill, hl};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs and queue the outputs the current state must show.
    task automatic cyc(input logic [5:0] op, input logic rdy, input logic [3:0] s,
                       input string tag);
        opcode   = op;
        memReady = rdy;
        expQ.push_back({s, expCtl(s, rdy, op)});
        tagQ.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            logic [21:0] e;
            string t;
            e = expQ.pop_front();
            t = tagQ.pop_front();
            checks++;
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", t, obs, e);
            end
        end
    end

    initial begin
        rst_n = 1'b0; opcode = '0; memReady = 1'b0;
        #3;
        check("reset_outputs", 64'(obs), 64'd0);
`ifdef MC_PERF_COUNTERS_EN
        check("reset_cycleCount", 64'(cycleCount), 64'd0);
        check("reset_instrCount", 64'(instrCount), 64'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_after_release", 64'(obs), 64'd0);
        @(posedge clk);
        #1;

        // lw with one FETCH stall
        cyc(LW, 0, 4'd1, "lw_fetch_stall");
        cyc(LW, 1, 4'd1, "lw_fetch");
        cyc(LW, 1, 4'd2, "lw_decode");
        cyc(LW, 1, 4'd3, "lw_memaddr");
        cyc(LW, 1, 4'd4, "lw_memread");
        cyc(LW, 1, 4'd5, "lw_memwb");

        // sw with three MEM_WRITE stalls
        cyc(SW, 1, 4'd1, "sw_fetch");
        cyc(SW, 1, 4'd2, "sw_decode");
        cyc(SW, 1, 4'd3, "sw_memaddr");
        cyc(SW, 0, 4'd6, "sw_memwrite_w1");
        cyc(SW, 0, 4'd6, "sw_memwrite_w2");
        cyc(SW, 0, 4'd6, "sw_memwrite_w3");
        cyc(SW, 1, 4'd6, "sw_memwrite");

        cyc(RT, 1, 4'd1, "r_fetch");
        cyc(RT, 0, 4'd2, "r_decode");
        cyc(RT, 0, 4'd7, "r_execute");
        cyc(RT, 1, 4'd8, "r_wb");

        cyc(ADDI, 1, 4'd1, "addi_fetch");
        cyc(ADDI, 1, 4'd2, "addi_decode");
        cyc(ADDI, 1, 4'd9, "addi_ex");
        cyc(ADDI, 0, 4'd10, "addi_wb");

        cyc(BEQ, 1, 4'd1, "beq_fetch");
        cyc(BEQ, 0, 4'd2, "beq_decode");
        cyc(BEQ, 0, 4'd11, "beq_branch");

        cyc(JMP, 1, 4'd1, "j_fetch");
        cyc(JMP, 1, 4'd2, "j_decode");
        cyc(JMP, 1, 4'd12, "j_jump");

        cyc(ILL, 1, 4'd1, "ill_fetch");
        cyc(ILL, 1, 4'd2, "ill_decode");

        // lw with a MEM_READ stall, then back to FETCH
        cyc(LW, 1, 4'd1, "lw2_fetch");
        cyc(LW, 1, 4'd2, "lw2_decode");
        cyc(LW, 1, 4'd3, "lw2_memaddr");
        cyc(LW, 0, 4'd4, "lw2_memread_wait");
        cyc(LW, 1, 4'd4, "lw2_memread");
        cyc(LW, 1, 4'd5, "lw2_memwb");

        // asynchronous reset in the middle of MEM_READ
        cyc(LW, 1, 4'd1, "lw3_fetch");
        cyc(LW, 1, 4'd2, "lw3_decode");
        cyc(LW, 1, 4'd3, "lw3_memaddr");
        memReady = 1'b0;
        #1;
        check("pre_reset_state", 64'(state), 64'd4);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 64'(obs), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        cyc(RT, 1, 4'd1, "c_r_fetch");
        cyc(RT, 1, 4'd2, "c_r_decode");
        cyc(RT, 1, 4'd7, "c_r_execute");
        cyc(RT, 1, 4'd8, "c_r_wb");
        cyc(ADDI, 1, 4'd1, "c_addi_fetch");
        cyc(ADDI, 1, 4'd2, "c_addi_decode");
        cyc(ADDI, 1, 4'd9, "c_addi_ex");
        cyc(ADDI, 1, 4'd10, "c_addi_wb");
        cyc(LW, 1, 4'd1, "c_lw_fetch");
        cyc(LW, 1, 4'd2, "c_lw_decode");
        cyc(LW, 1, 4'd3, "c_lw_memaddr");
        cyc(LW, 1, 4'd4, "c_lw_memread");
        cyc(LW, 1, 4'd5, "c_lw_memwb");
`ifdef MC_PERF_COUNTERS_EN
        check("instrCount_after3", 64'(instrCount), 64'd3);
        check("cycleCount_after3", 64'(cycleCount), 64'd13);
`endif

        cyc(HLT, 1, 4'd1, "halt_fetch");
        cyc(HLT, 1, 4'd2, "halt_decode");
        for (int i = 0; i < 20; i++)
            cyc(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 4'd13, "halt_hold");

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
